// File: rtl/pc_sequencer_pkg.sv
// Shared types and default sizing for the fetch-stage program-counter sequencer.
package pc_seq_pkg;
   localparam int PC_W_DEF      = 8;
   localparam int OFF_W_DEF     = 6;
   localparam int RAS_DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      NPC_HOLD,
      NPC_INC,
      NPC_ABS,
      NPC_REL,
      NPC_RET
   } npc_sel_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the core's fetch control and the PC sequencer.
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int OFF_W     = OFF_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) ();
   logic                         Halt;
   logic                         jump;
   logic                         branch_rel;
   logic                         call;
   logic                         ret;
   logic [PC_W-1:0]              target;
   logic [OFF_W-1:0]             offset;
   logic                         clr_err;
   logic [PC_W-1:0]              PC;
   logic [$clog2(RAS_DEPTH):0]   ras_count;
   logic                         ras_ovf;
   logic                         ras_unf;

   modport master (
      output Halt, jump, branch_rel, call, ret, target, offset, clr_err,
      input  PC, ras_count, ras_ovf, ras_unf
   );

   modport slave (
      input  Halt, jump, branch_rel, call, ret, target, offset, clr_err,
      output PC, ras_count, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: saturating count, a push onto a full stack overwrites the oldest entry.
module ras_stack
   import pc_seq_pkg::*;
#(
   parameter int RAS_DEPTH = RAS_DEPTH_DEF,
   parameter int PC_W      = PC_W_DEF
) (
   input  logic                       CLK,
   input  logic                       Reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [PC_W-1:0]            push_data,
   output logic [PC_W-1:0]            top,
   output logic [$clog2(RAS_DEPTH):0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PC_W-1:0]  mem [RAS_DEPTH];
   logic [PTR_W-1:0] wr_ptr;

   // wr_ptr names the next free slot, so the wrap onto the oldest entry falls out of the modulo pointer
   assign top   = mem[wr_ptr - PTR_W'(1)];
   assign full  = (count == CNT_W'(RAS_DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + PTR_W'(1);
         if (!full)
            count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         wr_ptr <= wr_ptr - PTR_W'(1);
         count  <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: halt, jump, relative branch and call/return with sticky RAS error flags.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int OFF_W     = OFF_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic           CLK,
   input  logic           Reset_n,
   pc_sequencer_if.slave  bus
);
   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   npc_sel_t          npc_sel;
   logic              push;
   logic              pop;
   logic              ovf_set;
   logic              unf_set;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_inc;
   logic [PC_W-1:0]   pc_rel;
   logic [PC_W-1:0]   ras_top;
   logic [CNT_W-1:0]  ras_cnt;
   logic              ras_full;
   logic              ras_empty;
   logic              ovf_q;
   logic              unf_q;

   assign pc_inc = pc_q + PC_W'(1);
   assign pc_rel = pc_q + PC_W'(signed'(bus.offset));

   // Priority decode; ret shadows call so a simultaneous pair never pushes
   always_comb begin
      npc_sel = NPC_INC;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (bus.Halt) begin
         npc_sel = NPC_HOLD;
      end else if (bus.ret) begin
         if (ras_empty) begin
            npc_sel = NPC_INC;
            unf_set = 1'b1;
         end else begin
            npc_sel = NPC_RET;
            pop     = 1'b1;
         end
      end else if (bus.call) begin
         npc_sel = NPC_ABS;
         push    = 1'b1;
         ovf_set = ras_full;
      end else if (bus.jump) begin
         npc_sel = NPC_ABS;
      end else if (bus.branch_rel) begin
         npc_sel = NPC_REL;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         pc_q <= '0;
      end else begin
         case (npc_sel)
            NPC_HOLD: pc_q <= pc_q;
            NPC_INC:  pc_q <= pc_inc;
            NPC_ABS:  pc_q <= bus.target;
            NPC_REL:  pc_q <= pc_rel;
            NPC_RET:  pc_q <= ras_top;
            default:  pc_q <= pc_q;
         endcase
      end
   end

   // A fresh error outranks clr_err in the same cycle
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
         unf_q <= unf_set | (unf_q & ~bus.clr_err);
      end
   end

   ras_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .PC_W      (PC_W)
   ) u_ras (
      .CLK       (CLK),
      .Reset_n   (Reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .count     (ras_cnt),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign bus.PC        = pc_q;
   assign bus.ras_count = ras_cnt;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed PC/RAS expectations.
module tb_pc_sequencer;
   logic CLK;
   logic Reset_n;
   int   error_count;
   int   check_count;

   pc_sequencer_if #(.PC_W(8), .OFF_W(6), .RAS_DEPTH(4)) bus ();

   pc_sequencer #(.PC_W(8), .OFF_W(6), .RAS_DEPTH(4)) dut (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [7:0] pc, input logic [2:0] cnt,
                             input logic ovf, input logic unf);
      checkOutput({tag, "_pc"},  32'(bus.PC),        32'(pc));
      checkOutput({tag, "_cnt"}, 32'(bus.ras_count), 32'(cnt));
      checkOutput({tag, "_ovf"}, 32'(bus.ras_ovf),   32'(ovf));
      checkOutput({tag, "_unf"}, 32'(bus.ras_unf),   32'(unf));
   endtask

   // Drive one cycle of control, then sample 1 ns after the rising edge
   task automatic applyStimulus(input logic halt, input logic jmp, input logic br, input logic cl,
                                input logic rt, input logic [7:0] tgt, input logic [5:0] off,
                                input logic clr);
      bus.Halt       = halt;
      bus.jump       = jmp;
      bus.branch_rel = br;
      bus.call       = cl;
      bus.ret        = rt;
      bus.target     = tgt;
      bus.offset     = off;
      bus.clr_err    = clr;
      @(posedge CLK);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 1'b0);
   endtask

   initial begin
      error_count    = 0;
      check_count    = 0;
      Reset_n        = 1'b0;
      bus.Halt       = 1'b0;
      bus.jump       = 1'b0;
      bus.branch_rel = 1'b0;
      bus.call       = 1'b0;
      bus.ret        = 1'b0;
      bus.target     = 8'h00;
      bus.offset     = 6'h00;
      bus.clr_err    = 1'b0;

      repeat (2) @(posedge CLK);
      #1;
      checkState("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      Reset_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         idleCycle();
         checkOutput("free_run_pc", 32'(bus.PC), 32'((i + 1) % 256));
      end

      // Asynchronous reset between edges
      #1;
      Reset_n = 1'b0;
      #1;
      checkState("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0);
      Reset_n = 1'b1;
      idleCycle();
      checkOutput("post_reset_first_inc", 32'(bus.PC), 32'h01);

      // Relative branches
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 6'h00, 1'b0);
      checkOutput("jump_0x10", 32'(bus.PC), 32'h10);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'b111101, 1'b0);
      checkOutput("branch_minus3", 32'(bus.PC), 32'h0D);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd5, 1'b0);
      checkOutput("branch_plus5_wrap", 32'(bus.PC), 32'h03);

      // Single call/return
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 6'h00, 1'b0);
      checkState("call_0x80", 8'h80, 3'd1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret_0x21", 8'h21, 3'd0, 1'b0, 1'b0);

      // Five nested calls overflow a 4-deep stack, losing link 0x02
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 6'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 6'h00, 1'b0);
      checkState("four_calls", 8'h41, 3'd4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 6'h00, 1'b0);
      checkState("fifth_call", 8'h50, 3'd4, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret1", 8'h42, 3'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret2", 8'h32, 3'd2, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret3", 8'h22, 3'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret4", 8'h12, 3'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret5_underflow", 8'h13, 3'd0, 1'b1, 1'b1);

      // Halt freezes everything while other controls toggle
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 6'h00, 1'b0);
      checkState("call_0x60", 8'h60, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 6'h00, 1'b0);
      checkState("halt_call", 8'h60, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 6'h03, 1'b0);
      checkState("halt_jump", 8'h60, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("halt_ret", 8'h60, 3'd1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 1'b1);
      checkState("halt_clr_err", 8'h60, 3'd1, 1'b0, 1'b0);

      // Simultaneous controls
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33, 6'h00, 1'b0);
      checkState("call_ret_pop_only", 8'h14, 3'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b0);
      checkState("ret_empty_no_push", 8'h15, 3'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'h00, 1'b1);
      checkState("clr_vs_new_unf", 8'h16, 3'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA0, 6'd5, 1'b0);
      checkState("jump_over_branch", 8'hA0, 3'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 1'b1);
      checkState("clr_err_alone", 8'hA1, 3'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core's fetch stage; drives the instruction-memory address every cycle. Supports halt, absolute jump, PC-relative branch, and call/return via an internal return-address stack (RAS) with sticky overflow/underflow flags. Successor to the plain fetch counter: the same freeze/jump/advance semantics, generalised in width and extended with relative branches and subroutine linkage.

## Interface
- PC_W, 8: PC and target width; PC wraps modulo 2^PC_W.
- OFF_W, 6: signed relative-offset width; must be ≤ PC_W.
- RAS_DEPTH, 4: return-stack entries; power of two, ≥ 2.

Ports:
- CLK  in  1  sole clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Halt  in  1  freeze PC and RAS.
- jump  in  1  absolute jump to target.
- branch_rel  in  1  relative branch by offset.
- call  in  1  push link, jump to target.
- ret  in  1  pop RAS into PC.
- target  in  PC_W  absolute destination for jump/call.
- offset  in  OFF_W  signed displacement for branch_rel.
- clr_err  in  1  clear sticky flags.
- PC  out  PC_W  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  out  1  sticky: a push hit a full stack.
- ras_unf  out  1  sticky: a pop hit an empty stack.

## Operation
- Reset (Reset_n low, any time, asynchronous): PC=0, ras_count=0, ras_ovf=0, ras_unf=0. RAS contents are don't-care. Mid-operation reset discards any pending push or pop.
- Next-PC priority, highest first: Halt > ret > call > jump > branch_rel > increment.
- Halt: PC, RAS, ras_count and flags all hold. clr_err is still honoured.
- ret:
  - Stack non-empty: PC <= top, ras_count-1.
  - Stack empty: PC <= PC+1, ras_unf <= 1, ras_count stays 0.
- call: push link = PC+1 (mod 2^PC_W), PC <= target.
  - Not full: ras_count+1.
  - Full: push overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, ras_ovf <= 1.
- call and ret asserted together: ret wins; call is ignored with no push.
- jump: PC <= target.
- branch_rel: PC <= PC + sign_extend(offset), result truncated to PC_W (wraps both directions).
- Otherwise: PC <= PC+1; 2^PC_W-1 wraps to 0.
- Flags: clr_err clears both flags. A new error in the same cycle as clr_err wins, so that flag ends at 1.
- Unselected control inputs have no side effects.

## Timing
- All outputs are registered. Control sampled at edge N is reflected on PC, ras_count and flags after edge N.
- No combinational path from inputs to outputs.
- Redirect latency is one cycle: the instruction at the new PC is fetched in the cycle after the redirect command.
- RAS read is combinational from the top pointer inside the block; the pop result lands in PC at the same edge.
- Reset deassertion is assumed synchronised upstream. The first increment occurs on the first rising edge with Reset_n high.

## Structure
- Package pc_seq_pkg holds:
  - enum npc_sel_t {NPC_HOLD, NPC_INC, NPC_ABS, NPC_REL, NPC_RET}
  - default parameter constants.
- The top level decodes the priority into npc_sel_t, then uses a single registered PC mux.
- Sub-module ras_stack:
  - Parameters: RAS_DEPTH, PC_W.
  - Signals: push, pop, push_data, top, count, full, empty.
  - Circular pointer with saturating count and overwrite-oldest on full.
  - Flags are owned by the top level.

## Test plan
- Reset then 300 free-running cycles (PC_W=8): PC = 0,1,…,255,0,1,…. Reset_n low mid-run forces PC=0 immediately, without waiting for a clock edge.
- PC=0x10 with branch_rel and offset=-3 (6'b111101) -> PC=0x0D. PC=0xFE with offset=+5 -> PC=0x03.
- PC=0x20 with call and target=0x80 -> PC=0x80, ras_count=1. Next cycle ret -> PC=0x21, ras_count=0.
- Five nested calls from PCs 0x01, 0x11, 0x21, 0x31, 0x41 (RAS_DEPTH=4):
  - After the calls: ras_ovf=1, ras_count=4.
  - Four rets return to 0x42, 0x32, 0x22, 0x12.
  - A fifth ret sets ras_unf=1 and gives PC=prev+1.
- Halt held 3 cycles while call, jump and ret toggle -> PC and ras_count unchanged. clr_err during Halt clears the flags.
- Simultaneous events:
  - call+ret with a non-empty stack -> pop only, no push.
  - jump+branch_rel -> PC=target.
  - clr_err with ret on an empty stack -> ras_unf stays 1.
